// File: rtl/score_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : score_keeper                                            |
// | Purpose  : Two-player score keeping with win detection, post-point |
// |            pause countdown, serve tracking and new-game restart.   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module score_keeper #(
   parameter int WIN_SCORE    = 11,
   parameter int WIN_MARGIN   = 2,
   parameter int PAUSE_FRAMES = 60,
   parameter int MAX_SCORE    = 99
) (
   input  logic       VGA_CLK,
   input  logic       RST_N,
   input  logic       GoalA,
   input  logic       GoalB,
   input  logic       FrameTick,
   input  logic       NewGame,
   output logic [6:0] ScoreA,
   output logic [6:0] ScoreB,
   output logic       ServeA,
   output logic       Paused,
   output logic       GameOver,
   output logic       WinnerA,
   output logic       ScoreEvt
);

   localparam int               c_CNT_W      = (PAUSE_FRAMES < 1) ? 1 : $clog2(PAUSE_FRAMES + 1);
   localparam logic [c_CNT_W-1:0] c_PAUSE_LOAD = c_CNT_W'(PAUSE_FRAMES);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
   localparam logic [7:0]       c_MAX        = 8'(MAX_SCORE);
   localparam logic [7:0]       c_WIN        = 8'(WIN_SCORE);
   localparam logic [7:0]       c_MARGIN     = 8'(WIN_MARGIN);

   typedef enum logic [1:0] {
      ST_PLAY  = 2'd0,
      ST_PAUSE = 2'd1,
      ST_OVER  = 2'd2
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [6:0]           r_score_a, r_score_b, w_score_a_nxt, w_score_b_nxt;
   logic                 r_serve_a, r_winner_a, r_score_evt;
   logic                 w_serve_a_nxt, w_winner_a_nxt, w_score_evt_nxt;
   logic                 r_goal_a_d, r_goal_b_d, r_new_game_d;

   // Rising-edge detection against the previous-cycle copy of each input
   logic w_edge_a, w_edge_b, w_edge_new;
   assign w_edge_a   = GoalA   & ~r_goal_a_d;
   assign w_edge_b   = GoalB   & ~r_goal_b_d;
   assign w_edge_new = NewGame & ~r_new_game_d;

   // 8-bit score arithmetic: saturating increments and lead comparisons never wrap
   logic [7:0] w_a8, w_b8, w_a_inc, w_b_inc;
   logic       w_a_wins, w_b_wins;
   assign w_a8     = {1'b0, r_score_a};
   assign w_b8     = {1'b0, r_score_b};
   assign w_a_inc  = (w_a8 >= c_MAX) ? c_MAX : w_a8 + 8'd1;
   assign w_b_inc  = (w_b8 >= c_MAX) ? c_MAX : w_b8 + 8'd1;
   // A point scored while already at the ceiling ends the game outright
   assign w_a_wins = ((w_a_inc >= c_WIN) && (w_a_inc >= w_b8) && ((w_a_inc - w_b8) >= c_MARGIN))
                     || (w_a8 == c_MAX);
   assign w_b_wins = ((w_b_inc >= c_WIN) && (w_b_inc >= w_a8) && ((w_b_inc - w_a8) >= c_MARGIN))
                     || (w_b8 == c_MAX);

   // Input history registers for edge detection
   always_ff @(posedge VGA_CLK) begin
      if (!RST_N) begin
         r_goal_a_d   <= 1'b0;
         r_goal_b_d   <= 1'b0;
         r_new_game_d <= 1'b0;
      end else begin
         r_goal_a_d   <= GoalA;
         r_goal_b_d   <= GoalB;
         r_new_game_d <= NewGame;
      end
   end

   // Next-state and next-datapath decode; NewGame outranks any goal
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_score_a_nxt   = r_score_a;
      w_score_b_nxt   = r_score_b;
      w_serve_a_nxt   = r_serve_a;
      w_winner_a_nxt  = r_winner_a;
      w_score_evt_nxt = 1'b0;
      if (w_edge_new) begin
         w_state_nxt    = ST_PAUSE;
         w_cnt_nxt      = c_PAUSE_LOAD;
         w_score_a_nxt  = 7'd0;
         w_score_b_nxt  = 7'd0;
         w_serve_a_nxt  = 1'b1;
         w_winner_a_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_PLAY: begin
               // Simultaneous goal edges are ambiguous and score nothing
               if (w_edge_a && !w_edge_b) begin
                  w_score_a_nxt   = w_a_inc[6:0];
                  w_score_evt_nxt = 1'b1;
                  w_serve_a_nxt   = 1'b0;
                  if (w_a_wins) begin
                     w_state_nxt    = ST_OVER;
                     w_winner_a_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_PAUSE;
                     w_cnt_nxt   = c_PAUSE_LOAD;
                  end
               end else if (w_edge_b && !w_edge_a) begin
                  w_score_b_nxt   = w_b_inc[6:0];
                  w_score_evt_nxt = 1'b1;
                  w_serve_a_nxt   = 1'b1;
                  if (w_b_wins) begin
                     w_state_nxt    = ST_OVER;
                     w_winner_a_nxt = 1'b0;
                  end else begin
                     w_state_nxt = ST_PAUSE;
                     w_cnt_nxt   = c_PAUSE_LOAD;
                  end
               end
            end
            ST_PAUSE: begin
               // Leaving on the cycle after the count has drained keeps a zero load to one cycle
               if (r_cnt == '0) begin
                  w_state_nxt = ST_PLAY;
               end else if (FrameTick) begin
                  w_cnt_nxt = r_cnt - c_CNT_ONE;
               end
            end
            ST_OVER: begin
               w_state_nxt = ST_OVER;
            end
            default: begin
               w_state_nxt = ST_PAUSE;
               w_cnt_nxt   = c_PAUSE_LOAD;
            end
         endcase
      end
   end

   // State, counter and score registers
   always_ff @(posedge VGA_CLK) begin
      if (!RST_N) begin
         r_state     <= ST_PAUSE;
         r_cnt       <= c_PAUSE_LOAD;
         r_score_a   <= 7'd0;
         r_score_b   <= 7'd0;
         r_serve_a   <= 1'b1;
         r_winner_a  <= 1'b0;
         r_score_evt <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_score_a   <= w_score_a_nxt;
         r_score_b   <= w_score_b_nxt;
         r_serve_a   <= w_serve_a_nxt;
         r_winner_a  <= w_winner_a_nxt;
         r_score_evt <= w_score_evt_nxt;
      end
   end

   assign ScoreA   = r_score_a;
   assign ScoreB   = r_score_b;
   assign ServeA   = r_serve_a;
   assign WinnerA  = r_winner_a;
   assign ScoreEvt = r_score_evt;
   assign Paused   = (r_state == ST_PAUSE);
   assign GameOver = (r_state == ST_OVER);

endmodule
`default_nettype wire

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The module SHALL have parameter WIN_SCORE, default 11, meaning the minimum score needed to win.
REQ-002 The module SHALL have parameter WIN_MARGIN, default 2, meaning the minimum lead needed to win.
REQ-003 The module SHALL have parameter PAUSE_FRAMES, default 60, meaning the number of FrameTick pulses to wait after a point.
REQ-004 The module SHALL have parameter MAX_SCORE, default 99, meaning the saturation value of each score.
REQ-005 The module SHALL have port VGA_CLK, input, 1 bit: the single clock.
REQ-006 The module SHALL have port RST_N, input, 1 bit: synchronous, active-low reset.
REQ-007 The module SHALL have port GoalA, input, 1 bit: a level that is high while the ball is in B's goal zone (a point for A); it may stay high for many cycles.
REQ-008 The module SHALL have port GoalB, input, 1 bit: the same as GoalA, for a point to B.
REQ-009 The module SHALL have port FrameTick, input, 1 bit: a one-cycle pulse at the start of each video frame.
REQ-010 The module SHALL have port NewGame, input, 1 bit: a level request to restart; only its rising edge acts.
REQ-011 The module SHALL have port ScoreA, output, 7 bits: player A's score, registered, feeding the score display.
REQ-012 The module SHALL have port ScoreB, output, 7 bits: player B's score, registered.
REQ-013 The module SHALL have port ServeA, output, 1 bit: 1 means A serves next and 0 means B serves next.
REQ-014 The module SHALL have port Paused, output, 1 bit: high while the FSM is in PAUSE.
REQ-015 The module SHALL have port GameOver, output, 1 bit: high while the FSM is in OVER.
REQ-016 The module SHALL have port WinnerA, output, 1 bit: valid only when GameOver=1; 1 means A won.
REQ-017 The module SHALL have port ScoreEvt, output, 1 bit: a one-cycle pulse marking each accepted point.

Function
REQ-018 The module SHALL register GoalA, GoalB and NewGame once and detect rising edges as current=1 and previous=0.
REQ-019 The FSM SHALL have exactly three states: PLAY, PAUSE and OVER.
REQ-020 A goal edge SHALL be accepted only in PLAY; goal edges seen in PAUSE or OVER SHALL be ignored.
REQ-021 If a GoalA edge and a GoalB edge occur in the same cycle, neither SHALL score, state SHALL NOT change and ScoreEvt SHALL stay 0.
REQ-022 On an accepted point, the cycle after the edge SHALL show the new score, ScoreEvt=1 and ServeA set to the loser of the point (1 if B scored).
REQ-023 Each score increment SHALL saturate at MAX_SCORE; all score arithmetic SHALL be 8-bit unsigned with no wrap.
REQ-024 Win check, on the new score: scorer's new score >= WIN_SCORE and (scorer's score - other's score) >= WIN_MARGIN; or the scorer's old score already equals MAX_SCORE.
REQ-025 If the win check holds, the FSM SHALL go PLAY->OVER and set WinnerA to the scorer; otherwise it SHALL go PLAY->PAUSE and load the pause counter with PAUSE_FRAMES.
REQ-026 In PAUSE, each FrameTick SHALL decrement the counter; the cycle after the counter reaches 0, the FSM SHALL go PAUSE->PLAY.
REQ-027 If PAUSE_FRAMES=0, PAUSE SHALL last exactly one cycle.
REQ-028 A NewGame edge in any state SHALL, on the next cycle, clear both scores, set ServeA=1, load the counter with PAUSE_FRAMES and enter PAUSE.
REQ-029 NewGame SHALL take priority over a same-cycle goal edge.
REQ-030 In OVER, the scores and WinnerA SHALL hold until NewGame or reset.
REQ-031 The outputs Paused and GameOver SHALL be decoded directly from the registered state, with no extra latency.

Reset
REQ-032 When RST_N=0 at a VGA_CLK edge, the next state SHALL be: ScoreA=0, ScoreB=0, ServeA=1, WinnerA=0, ScoreEvt=0, FSM in PAUSE with counter=PAUSE_FRAMES, Paused=1, GameOver=0, and edge-detect history cleared to 0.
REQ-033 Reset SHALL override everything, including a mid-pause countdown and OVER.
REQ-034 A goal input held high through the release of reset SHALL NOT count as an edge.

Verification
REQ-035 Reset release, then 60 FrameTicks -> Paused drops to 0 one cycle after the 60th tick; GoalA held high for 5 cycles -> ScoreA=1 with one ScoreEvt pulse, ServeA=0, Paused=1.
REQ-036 A=10, B=9, then GoalA -> A=11, lead of 2 -> GameOver=1, WinnerA=1, no PAUSE entered; further goal edges -> scores unchanged.
REQ-037 Deuce at A=10, B=10, then GoalA -> 11:10, PAUSE; then GoalB -> 11:11, PAUSE; then GoalB, GoalB -> the second point gives 11:13 and WinnerA=0.
REQ-038 GoalA and GoalB rising in the same cycle during PLAY -> scores, state and ScoreEvt all unchanged.
REQ-039 A=99, B=98, then GoalB -> B=99, PAUSE; then GoalA -> A stays 99, GameOver=1, WinnerA=1.
REQ-040 In OVER, NewGame edge plus a GoalB edge in the same cycle -> scores 0:0, ServeA=1, Paused=1, ScoreEvt=0; RST_N=0 during a PAUSE countdown -> counter reloads to PAUSE_FRAMES.
